// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared RV32 and branch-predictor types and constants
package RV32Consts;
    typedef logic [31:0] IntReg;
endpackage

package BranchPredConsts;
    typedef logic [1:0] ctr2_t;

    // Weakly not-taken: first taken resolution flips the prediction.
    localparam ctr2_t WNT = 2'b01;

    typedef struct packed {
        logic              valid;
        RV32Consts::IntReg pc;
    } redirect_t;
endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch/resolve/redirect signal bundle for the branch predictor
interface branch_predictor_if;
    import RV32Consts::*;

    IntReg fetch_pc;
    logic  pred_taken;
    IntReg pred_target;
    logic  res_valid;
    IntReg res_pc;
    logic  res_taken;
    IntReg res_target;
    logic  res_pred_taken;
    IntReg res_pred_target;
    logic  redirect_valid;
    IntReg redirect_pc;
    IntReg branch_count;
    IntReg mispredict_count;

    // Pipeline side: issues fetch and resolve information, consumes predictions.
    modport master (
        output fetch_pc, res_valid, res_pc, res_taken, res_target,
               res_pred_taken, res_pred_target,
        input  pred_taken, pred_target, redirect_valid, redirect_pc,
               branch_count, mispredict_count
    );

    // Predictor side.
    modport slave (
        input  fetch_pc, res_valid, res_pc, res_taken, res_target,
               res_pred_taken, res_pred_target,
        output pred_taken, pred_target, redirect_valid, redirect_pc,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating up/down counter next-state logic
module sat_counter2
    import BranchPredConsts::*;
(
    input  ctr2_t cur,
    input  logic  taken,
    output ctr2_t next
);

    // Count toward the resolved direction, holding at 0 and 3.
    always_comb begin
        next = cur;
        if (taken && (cur != 2'b11)) begin
            next = cur + 2'd1;
        end else if (!taken && (cur != 2'b00)) begin
            next = cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - tagless bimodal BHT/BTB with registered redirect and perf counters
module branch_predictor
    import RV32Consts::*;
    import BranchPredConsts::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    input  IntReg fetch_pc,
    output logic  pred_taken,
    output IntReg pred_target,
    input  logic  res_valid,
    input  IntReg res_pc,
    input  logic  res_taken,
    input  IntReg res_target,
    input  logic  res_pred_taken,
    input  IntReg res_pred_target,
    output logic  redirect_valid,
    output IntReg redirect_pc,
    output IntReg branch_count,
    output IntReg mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    ctr2_t              ctr_q [ENTRIES];
    IntReg              tgt_q [ENTRIES];
    logic [ENTRIES-1:0] vld_q;

    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] res_idx;
    ctr2_t            ctr_next;
    logic             mispredict;
    redirect_t        redir_d;
    redirect_t        redir_q;
    IntReg            branch_cnt_q;
    IntReg            mispredict_cnt_q;
    logic             unused_fetch_bits;

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign res_idx   = res_pc[IDX_W+1:2];

    // Tables are tagless, so the PC bits outside the index carry no meaning here.
    assign unused_fetch_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0]};

    // Reads come straight from the registered tables, so a same-cycle update
    // to the same entry is only seen from the next cycle on.
    assign pred_taken  = ctr_q[fetch_idx][1] & vld_q[fetch_idx];
    assign pred_target = vld_q[fetch_idx] ? tgt_q[fetch_idx] : '0;

    sat_counter2 u_sat (
        .cur   (ctr_q[res_idx]),
        .taken (res_taken),
        .next  (ctr_next)
    );

    assign mispredict = res_valid &
                        ((res_taken != res_pred_taken) |
                         (res_taken & (res_target != res_pred_target)));

    // Redirect to the real target when taken, otherwise to the fall-through PC.
    always_comb begin
        redir_d       = '0;
        redir_d.valid = mispredict;
        redir_d.pc    = res_taken ? res_target : (res_pc + 32'd4);
    end

    // BHT/BTB update on each resolved control transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= WNT;
                tgt_q[i] <= '0;
            end
            vld_q <= '0;
        end else if (res_valid) begin
            ctr_q[res_idx] <= ctr_next;
            if (res_taken) begin
                tgt_q[res_idx] <= res_target;
                vld_q[res_idx] <= 1'b1;
            end
        end
    end

    // One-cycle redirect pulse; the PC only moves when a new redirect fires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redir_q <= '0;
        end else begin
            redir_q.valid <= redir_d.valid;
            if (redir_d.valid) begin
                redir_q.pc <= redir_d.pc;
            end
        end
    end

    // Free-running performance counters, wrapping naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (res_valid) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mispredict) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

    assign redirect_valid   = redir_q.valid;
    assign redirect_pc      = redir_q.pc;
    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispredict_cnt_q;

endmodule
